// File: rtl/apb_pkg.sv
// Shared definitions for the round-robin APB master: FSM encoding,
// default bus widths and the channel-index width helper.
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter. Searches from the channel after the last grant,
// wrapping modulo NUM_CH. The pointer moves only on an advance strobe
// with at least one request present, so channel 0 wins first after reset.
module rr_arbiter
  import apb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  localparam int CW     = ch_width(NUM_CH)
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] gnt,
  output logic [CW-1:0]     gnt_idx
);

  logic [CW-1:0] last_grant;

  // Pick the first requester after last_grant, wrapping around
  always_comb begin
    int  idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = (int'(last_grant) + i) % NUM_CH;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = CW'(idx);
      end
    end
  end

  // Remember the winner so it goes to the back of the line
  always_ff @(posedge pclk) begin
    if (reset)
      last_grant <= CW'(NUM_CH - 1);
    else if (advance && (|req))
      last_grant <= gnt_idx;
  end

endmodule

// File: rtl/apb_master_rr.sv
// Multi-channel APB3 master. Clients post read/write requests with a
// valid/ready handshake; a round-robin arbiter serialises them onto one
// APB port. Each completed transfer returns a one-cycle response tagged
// with its channel. Define APB_MASTER_TIMEOUT_EN to bound the number of
// wait states at TIMEOUT; without it ACCESS waits for pready forever.
module apb_master_rr
  import apb_pkg::*;
#(
  parameter  int ADDR_WIDTH = APB_ADDR_WIDTH,
  parameter  int DATA_WIDTH = APB_DATA_WIDTH,
  parameter  int NUM_CH     = 4,
  parameter  int TIMEOUT    = 255,
  localparam int CW         = ch_width(NUM_CH)
) (
  input  logic                         pclk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_wdata,
  output logic                         rsp_valid,
  output logic [CW-1:0]                rsp_ch,
  output logic [DATA_WIDTH-1:0]        rsp_rdata,
  output logic                         rsp_err,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_WIDTH-1:0]        paddr,
  output logic [DATA_WIDTH-1:0]        pwdata,
  input  logic [DATA_WIDTH-1:0]        prdata,
  input  logic                         pready,
  input  logic                         pslverr
);

  apb_state_e state, state_nxt;

  logic [NUM_CH-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] wdata_v;
  logic [NUM_CH-1:0]                 gnt;
  logic [CW-1:0]                     gnt_idx;
  logic [CW-1:0]                     cur_ch;
  logic                              any_req;
  logic                              to_hit;
  logic                              complete;
  logic                              grant_en;

  assign addr_v  = req_addr;
  assign wdata_v = req_wdata;
  assign any_req = |req_valid;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Count wait states of the current ACCESS phase; zero outside ACCESS
  always_ff @(posedge pclk) begin
    if (reset || state != ACCESS)
      wait_cnt <= '0;
    else if (!pready && !to_hit)
      wait_cnt <= wait_cnt + TW'(1);
  end

  // A real pready on the limit cycle still wins over the timeout
  assign to_hit = (state == ACCESS) && !pready && (wait_cnt == TW'(TIMEOUT));
`else
  assign to_hit = 1'b0;
`endif

  // A transfer ends on pready (or a forced timeout) during ACCESS; the bus
  // is free for a new grant in IDLE or on that completing cycle.
  assign complete = (state == ACCESS) && (pready || to_hit);
  assign grant_en = !reset && ((state == IDLE) || complete);
  assign req_ready = grant_en ? gnt : '0;

  assign psel    = (state != IDLE);
  assign penable = (state == ACCESS);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .pclk    (pclk),
    .reset   (reset),
    .req     (req_valid),
    .advance (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // State register
  always_ff @(posedge pclk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: back-to-back transfers skip IDLE when a grant coincides
  // with completion
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (complete) state_nxt = any_req ? SETUP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the granted request; held through SETUP and every wait state
  always_ff @(posedge pclk) begin
    if (reset) begin
      pwrite <= 1'b0;
      paddr  <= '0;
      pwdata <= '0;
      cur_ch <= '0;
    end else if (grant_en && any_req) begin
      pwrite <= req_write[gnt_idx];
      paddr  <= addr_v[gnt_idx];
      pwdata <= req_write[gnt_idx] ? wdata_v[gnt_idx] : '0;
      cur_ch <= gnt_idx;
    end
  end

  // Response pulse the cycle after completion; timeouts report an error
  // with zero data, writes always return zero data
  always_ff @(posedge pclk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_ch    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= complete;
      if (complete) begin
        rsp_ch    <= cur_ch;
        rsp_err   <= pready ? pslverr : 1'b1;
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master_rr.sv
// Bench for apb_master_rr: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin / APB timing model.
// Inputs change 1ns after posedge; outputs are sampled on negedge.
module tb_apb_master_rr;

  localparam int AW = 8;
  localparam int DW = 24;
  localparam int NC = 4;
  localparam int TO = 4;
  localparam int CW = 2;

  logic              pclk = 1'b0;
  logic              reset;
  logic [NC-1:0]     req_valid, req_ready, req_write;
  logic [NC*AW-1:0]  req_addr;
  logic [NC*DW-1:0]  req_wdata;
  logic              rsp_valid, rsp_err;
  logic [CW-1:0]     rsp_ch;
  logic [DW-1:0]     rsp_rdata;
  logic              psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [DW-1:0]     pwdata, prdata;
  logic              pready, pslverr;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_master_rr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_CH(NC), .TIMEOUT(TO)) dut (
    .pclk(pclk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ch(rsp_ch), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  task automatic to_next(); @(posedge pclk); #1; endtask
  task automatic smp();     @(negedge pclk);     endtask

  task automatic clear_inputs();
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
  endtask

  task automatic set_req(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[c] = 1'b1;
    req_write[c] = w;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*DW +: DW] = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    to_next(); to_next();
    reset = 1'b0;
    to_next();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    to_next(); to_next();
    req_valid = '1;
    smp();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    checks++; if ({psel, penable, pwrite} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b exp 000", {psel, penable, pwrite}); end
    checks++; if (paddr !== '0 || pwdata !== '0) begin errors++; $display("FAIL reset_bus paddr %h pwdata %h exp 0", paddr, pwdata); end
    checks++; if ({rsp_valid, rsp_err} !== 2'b00 || rsp_ch !== '0 || rsp_rdata !== '0) begin
      errors++; $display("FAIL reset_rsp v%b e%b ch%0d d%h exp all 0", rsp_valid, rsp_err, rsp_ch, rsp_rdata); end
    to_next();
    reset = 1'b0;
    req_valid = '0;
    to_next();
  endtask

  // All channels held valid from reset: grants 0,1,2,3,0 every 2 cycles
  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [AW-1:0] pa [5];
    logic [DW-1:0] pd [5];
    logic          pw [5];
    logic [DW-1:0] rd;
    logic [NC-1:0] exp_r;
    rd = DW'($urandom);
    prdata = rd; pready = 1'b1; pslverr = 1'b0;
    for (int c = 0; c < NC; c++) set_req(c, 1'($urandom), AW'($urandom), DW'($urandom));
    for (int k = 0; k < 12; k++) begin
      if (k > 8) req_valid = '0;
      else if (k % 2 == 1) set_req(order[(k-1)/2], 1'($urandom), AW'($urandom), DW'($urandom));
      smp();
      exp_r = (k % 2 == 0 && k <= 8) ? (NC'(1) << order[k/2]) : '0;
      checks++; if (req_ready !== exp_r) begin errors++; $display("FAIL fair_ready k=%0d got %b exp %b", k, req_ready, exp_r); end
      if (k % 2 == 0 && k <= 8) begin
        pa[k/2] = req_addr[order[k/2]*AW +: AW];
        pw[k/2] = req_write[order[k/2]];
        pd[k/2] = pw[k/2] ? req_wdata[order[k/2]*DW +: DW] : '0;
      end
      checks++; if (psel !== (k >= 1 && k <= 10)) begin errors++; $display("FAIL fair_psel k=%0d got %b", k, psel); end
      if (k % 2 == 1 && k <= 9) begin
        checks++; if (paddr !== pa[(k-1)/2] || pwrite !== pw[(k-1)/2] || pwdata !== pd[(k-1)/2]) begin
          errors++; $display("FAIL fair_bus k=%0d got %h/%b/%h exp %h/%b/%h", k, paddr, pwrite, pwdata, pa[(k-1)/2], pw[(k-1)/2], pd[(k-1)/2]); end
      end
      checks++; if (rsp_valid !== (k % 2 == 1 && k >= 3)) begin errors++; $display("FAIL fair_rsp_valid k=%0d got %b", k, rsp_valid); end
      if (k % 2 == 1 && k >= 3) begin
        checks++; if (rsp_ch !== CW'(order[(k-3)/2]) || rsp_rdata !== (pw[(k-3)/2] ? '0 : rd) || rsp_err !== 1'b0) begin
          errors++; $display("FAIL fair_rsp k=%0d ch %0d d %h e %b exp ch %0d", k, rsp_ch, rsp_rdata, rsp_err, order[(k-3)/2]); end
      end
      to_next();
    end
    clear_inputs();
  endtask

  task automatic test_single_write();
    set_req(0, 1'b1, 8'h12, 24'hABCDEF);
    pready = 1'b1; prdata = 24'h777777;
    smp();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL sw_ready got %b exp 0001", req_ready); end
    to_next(); req_valid = '0; smp();
    checks++; if ({psel, penable} !== 2'b10 || paddr !== 8'h12 || pwdata !== 24'hABCDEF || pwrite !== 1'b1) begin
      errors++; $display("FAIL sw_setup sel/en %b%b addr %h data %h w %b", psel, penable, paddr, pwdata, pwrite); end
    to_next(); smp();
    checks++; if ({psel, penable} !== 2'b11) begin errors++; $display("FAIL sw_access got %b%b exp 11", psel, penable); end
    to_next(); smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0 || rsp_err !== 1'b0 || rsp_rdata !== '0 || psel !== 1'b0) begin
      errors++; $display("FAIL sw_rsp v%b ch%0d e%b d%h psel%b exp 1/0/0/0/0", rsp_valid, rsp_ch, rsp_err, rsp_rdata, psel); end
    to_next(); smp();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL sw_rsp_pulse got %b exp 0", rsp_valid); end
    to_next();
    clear_inputs();
  endtask

  task automatic test_wait_states();
    set_req(2, 1'b0, 8'h40, 24'h111111);
    pready = 1'b0;
    smp();
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ws_ready got %b exp 0100", req_ready); end
    to_next(); req_valid = '0; smp();
    checks++; if ({psel, penable} !== 2'b10 || paddr !== 8'h40 || pwdata !== '0 || pwrite !== 1'b0) begin
      errors++; $display("FAIL ws_setup sel/en %b%b addr %h data %h w %b", psel, penable, paddr, pwdata, pwrite); end
    for (int k = 2; k <= 5; k++) begin
      to_next();
      if (k == 5) begin pready = 1'b1; prdata = 24'h5A5A5A; end
      smp();
      checks++; if ({psel, penable} !== 2'b11 || paddr !== 8'h40 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL ws_hold k=%0d sel/en %b%b addr %h rsp %b", k, psel, penable, paddr, rsp_valid); end
    end
    to_next(); pready = 1'b0; smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 24'h5A5A5A || rsp_ch !== 2'd2 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL ws_rsp v%b d%h ch%0d e%b exp 1/5a5a5a/2/0", rsp_valid, rsp_rdata, rsp_ch, rsp_err); end
    to_next();
    clear_inputs();
  endtask

  task automatic test_slave_error();
    set_req(1, 1'b0, 8'h55, 24'h0);
    pready = 1'b1; pslverr = 1'b1; prdata = 24'h000001;
    smp();
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL se_ready got %b exp 0010", req_ready); end
    to_next(); req_valid = '0;
    to_next();
    to_next(); smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 24'h000001 || rsp_ch !== 2'd1) begin
      errors++; $display("FAIL se_rsp v%b e%b d%h ch%0d exp 1/1/000001/1", rsp_valid, rsp_err, rsp_rdata, rsp_ch); end
    to_next();
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] a0;
    set_req(3, 1'b0, 8'h33, 24'h0);
    pready = 1'b0;
    smp();
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rm_ready got %b exp 1000", req_ready); end
    to_next(); req_valid = '0;
    to_next(); smp();
    checks++; if (penable !== 1'b1) begin errors++; $display("FAIL rm_access got %b exp 1", penable); end
    to_next();
    reset = 1'b1;
    a0 = AW'($urandom);
    set_req(0, 1'b1, a0, DW'($urandom));
    set_req(1, 1'b0, AW'($urandom), DW'($urandom));
    smp();
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_in_reset ready %b rsp %b exp 0", req_ready, rsp_valid); end
    to_next(); reset = 1'b0; pready = 1'b1; smp();
    checks++; if (psel !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_abandon psel %b rsp %b exp 0", psel, rsp_valid); end
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first got %b exp 0001", req_ready); end
    to_next(); req_valid[0] = 1'b0; smp();
    checks++; if ({psel, penable} !== 2'b10 || paddr !== a0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rm_setup sel/en %b%b addr %h exp %h rsp %b", psel, penable, paddr, a0, rsp_valid); end
    to_next(); smp();
    checks++; if (req_ready !== 4'b0010 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_second ready %b exp 0010 rsp %b", req_ready, rsp_valid); end
    to_next(); req_valid = '0; smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0) begin errors++; $display("FAIL rm_rsp0 v%b ch%0d exp 1/0", rsp_valid, rsp_ch); end
    to_next(); to_next(); smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd1 || psel !== 1'b0) begin errors++; $display("FAIL rm_rsp1 v%b ch%0d psel%b exp 1/1/0", rsp_valid, rsp_ch, psel); end
    to_next();
    clear_inputs();
  endtask

  task automatic test_timeout();
    set_req(0, 1'b0, 8'h77, 24'h0);
    pready = 1'b0; prdata = 24'hFFFFFF; pslverr = 1'b0;
    smp();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL to_ready got %b exp 0001", req_ready); end
    to_next(); req_valid = '0;
`ifdef APB_MASTER_TIMEOUT_EN
    // Four wait states are tolerated; the next pready=0 cycle is forced to end
    for (int k = 1; k <= 6; k++) begin
      smp();
      checks++; if (psel !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL to_wait k=%0d psel %b rsp %b", k, psel, rsp_valid); end
      to_next();
    end
    smp();
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== '0 || psel !== 1'b0) begin
      errors++; $display("FAIL to_rsp v%b e%b d%h psel%b exp 1/1/0/0", rsp_valid, rsp_err, rsp_rdata, psel); end
    to_next();
`else
    to_next();
    for (int k = 0; k < 100; k++) begin
      smp();
      checks++; if ({psel, penable} !== 2'b11 || rsp_valid !== 1'b0) begin
        errors++; $display("FAIL to_hang k=%0d sel/en %b%b rsp %b exp 11/0", k, psel, penable, rsp_valid); end
      to_next();
    end
`endif
    do_reset();
  endtask

  // Random traffic vs. a transaction model: round-robin choice from the
  // spec rule, transfer occupies grant+1 (SETUP) .. done (ACCESS end),
  // response the cycle after done. The bench slave picks 0..3 wait states.
  task automatic test_random_traffic();
    int mptr, g_cyc, done_cyc, rsp_cyc, t_ch, gch;
    bit busy;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wdata, r_data;
    logic          t_write, r_err;
    logic [CW-1:0] r_ch;
    logic [NC-1:0] exp_rdy;
    do_reset();
    mptr = NC - 1; busy = 0; rsp_cyc = -1; g_cyc = 0; done_cyc = 0; t_ch = 0; gch = 0;
    t_addr = '0; t_wdata = '0; t_write = 1'b0; r_data = '0; r_err = 1'b0; r_ch = '0;
    exp_rdy = '0;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NC; c++) begin
        if (exp_rdy[c]) req_valid[c] = 1'b0;
        if (!req_valid[c]) begin
          if (k < 520 && $urandom_range(2) == 0) set_req(c, 1'($urandom), AW'($urandom), DW'($urandom));
        end else if ($urandom_range(15) == 0) req_valid[c] = 1'b0;
      end
      if (busy && k == done_cyc) begin
        pready = 1'b1; prdata = DW'($urandom); pslverr = 1'($urandom);
      end else if (busy && k >= g_cyc + 2) begin
        pready = 1'b0; prdata = DW'($urandom); pslverr = 1'($urandom);
      end else begin
        pready = 1'($urandom); prdata = DW'($urandom); pslverr = 1'($urandom);
      end
      smp();
      exp_rdy = '0;
      if ((!busy || k == done_cyc) && (|req_valid)) begin
        for (int i = 1; i <= NC; i++) begin
          if (exp_rdy == '0 && req_valid[(mptr + i) % NC]) begin
            gch = (mptr + i) % NC;
            exp_rdy[gch] = 1'b1;
          end
        end
      end
      checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rnd_ready k=%0d got %b exp %b", k, req_ready, exp_rdy); end
      checks++; if (psel !== (busy && k > g_cyc) || penable !== (busy && k > g_cyc + 1)) begin
        errors++; $display("FAIL rnd_ctrl k=%0d sel/en %b%b", k, psel, penable); end
      if (busy && k > g_cyc) begin
        checks++; if (paddr !== t_addr || pwrite !== t_write || pwdata !== t_wdata) begin
          errors++; $display("FAIL rnd_bus k=%0d got %h/%b/%h exp %h/%b/%h", k, paddr, pwrite, pwdata, t_addr, t_write, t_wdata); end
      end
      checks++; if (rsp_valid !== (k == rsp_cyc)) begin errors++; $display("FAIL rnd_rsp_valid k=%0d got %b", k, rsp_valid); end
      if (k == rsp_cyc) begin
        checks++; if (rsp_ch !== r_ch || rsp_rdata !== r_data || rsp_err !== r_err) begin
          errors++; $display("FAIL rnd_rsp k=%0d got %0d/%h/%b exp %0d/%h/%b", k, rsp_ch, rsp_rdata, rsp_err, r_ch, r_data, r_err); end
      end
      if (busy && k == done_cyc) begin
        rsp_cyc = k + 1; r_ch = CW'(t_ch); r_err = pslverr;
        r_data = t_write ? '0 : prdata;
        busy = 0;
      end
      if (exp_rdy != '0) begin
        busy = 1; g_cyc = k; done_cyc = k + 2 + int'($urandom_range(3));
        t_ch = gch; mptr = gch;
        t_addr = req_addr[gch*AW +: AW];
        t_write = req_write[gch];
        t_wdata = t_write ? req_wdata[gch*DW +: DW] : '0;
      end
      to_next();
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_write();
    test_wait_states();
    test_slave_error();
    test_reset_mid();
    test_timeout();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
